// File: rtl/modadd_sched.sv
// Round-robin scheduler in front of a shared three-stage modular adder (a+b mod q).
// Owns the qH register and drains the adder before a new qH takes effect.
module modadd_sched #(
   parameter int               NREQ    = 4,
   parameter int               LOGQ    = 64,
   parameter int               LOGQH   = 47,
   parameter logic [LOGQH-1:0] QH_INIT = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*LOGQ-1:0]     req_a,
   input  logic [NREQ*LOGQ-1:0]     req_b,
   output logic                     out_valid,
   output logic [$clog2(NREQ)-1:0]  out_id,
   output logic [LOGQ-1:0]          out_data,
   input  logic                     cfg_we,
   input  logic [LOGQH-1:0]         cfg_qh,
   output logic                     cfg_ready,
   output logic                     cfg_ack,
   output logic [LOGQH-1:0]         qh_cur
);

   // state | meaning
   // RUN   | arbitrating requests, cfg_we accepted
   // DRAIN | issue blocked, waiting for the tag pipeline to empty
   // LOAD  | pending qH written into qh_reg, cfg_ack pulses

   localparam int IDW = $clog2(NREQ);
   localparam int LAT = 3;
   localparam int W   = LOGQ - LOGQH;

   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt;
   logic [IDW-1:0]   gnt_id;
   logic             gnt_found;
   logic             issue_en;
   logic [LOGQH-1:0] qh_reg, qh_pend;
   logic [LAT-1:0]   tag_v;
   logic [IDW-1:0]   tag_id [LAT];
   logic             busy;

   logic [LOGQ-1:0]  q;
   logic [LOGQ-1:0]  a_sel, b_sel;
   logic [LOGQ-1:0]  a1, b1;
   logic [LOGQ:0]    sum_w;
   logic [LOGQ-1:0]  sum2, dif2, res3;
   logic             ge2;

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && req_valid[(int'(ptr) + k) % NREQ]) begin
            gnt_found = 1'b1;
            gnt_id    = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   assign issue_en  = gnt_found && (state == RUN) && !rst;
   assign req_ready = issue_en ? (NREQ'(1) << gnt_id) : '0;
   assign ptr_nxt   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      cfg_ack   = 1'b0;
      unique case (state)
         RUN: begin
            cfg_ready = !rst;
            if (cfg_we) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!busy) state_nxt = LOAD;
         end
         LOAD: begin
            cfg_ack   = !rst;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         ptr     <= '0;
         qh_reg  <= QH_INIT;
         qh_pend <= QH_INIT;
      end else begin
         state <= state_nxt;
         if (issue_en) ptr <= ptr_nxt;
         if (state == RUN && cfg_we) qh_pend <= cfg_qh;
         if (state == LOAD) qh_reg <= qh_pend;
      end
   end

   assign qh_cur = qh_reg;

   // Tag pipeline carries validity and requester ID alongside the adder stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
         for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
      end else begin
         tag_v     <= {tag_v[LAT-2:0], issue_en};
         tag_id[0] <= gnt_id;
         for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
      end
   end

   assign busy      = |tag_v;
   assign out_valid = tag_v[LAT-1] && !rst;
   assign out_id    = tag_id[LAT-1];

   // qh_reg only changes while the pipeline is empty, so stage 2 can read it directly.
   assign q     = {qh_reg, {W{1'b0}}} + LOGQ'(1);
   assign a_sel = req_a[int'(gnt_id)*LOGQ +: LOGQ];
   assign b_sel = req_b[int'(gnt_id)*LOGQ +: LOGQ];
   assign sum_w = {1'b0, a1} + {1'b0, b1};

   always_ff @(posedge clk) begin
      if (issue_en) begin
         a1 <= a_sel;
         b1 <= b_sel;
      end
      sum2 <= sum_w[LOGQ-1:0];
      dif2 <= sum_w[LOGQ-1:0] - q;
      ge2  <= (sum_w >= {1'b0, q});
      res3 <= ge2 ? dif2 : sum2;
   end

   assign out_data = res3;

endmodule

// File: tb/tb_modadd_sched.sv
// Scoreboard bench for modadd_sched: arbitration/config model checked every cycle,
// expected results queued on issue and popped by an independent output monitor.
module tb_modadd_sched;
   localparam int NREQ = 4;
   localparam int LOGQ = 64;
   localparam int LOGQH = 47;
   localparam int W = LOGQ - LOGQH;
   localparam int LAT = 3;
   localparam logic [LOGQH-1:0] QH_INIT = '0;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*LOGQ-1:0] req_a = '0;
   logic [NREQ*LOGQ-1:0] req_b = '0;
   logic                 out_valid;
   logic [1:0]           out_id;
   logic [LOGQ-1:0]      out_data;
   logic                 cfg_we = 1'b0;
   logic [LOGQH-1:0]     cfg_qh = '0;
   logic                 cfg_ready;
   logic                 cfg_ack;
   logic [LOGQH-1:0]     qh_cur;

   typedef struct {
      int              id;
      logic [LOGQ-1:0] data;
      int              due;
   } exp_t;

   exp_t             sb[$];
   int               glog[$];
   int               cyc = 0;
   int               n_vec = 0;
   int               n_err = 0;
   int               gnt_cyc [NREQ];
   logic [LOGQH-1:0] m_qh = QH_INIT;

   modadd_sched #(.NREQ(NREQ), .LOGQ(LOGQ), .LOGQH(LOGQH), .QH_INIT(QH_INIT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
      .cfg_we(cfg_we), .cfg_qh(cfg_qh), .cfg_ready(cfg_ready), .cfg_ack(cfg_ack),
      .qh_cur(qh_cur)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   function automatic logic [LOGQ-1:0] qof(input logic [LOGQH-1:0] qh);
      return (64'(qh) << W) + 64'd1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_msg(input string nm, input string detail);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
   endtask

   // Reference model: round-robin rule, cfg handshake timing, qH-at-issue arithmetic.
   initial begin : model
      logic [NREQ-1:0]  exp_rdy;
      logic [LOGQH-1:0] pend;
      logic [LOGQ:0]    s;
      logic [LOGQ-1:0]  a, b, q;
      int               g, m_ptr, last_issue, ack_due;
      bit               blocked;
      pend = '0; m_ptr = 0; last_issue = -100; ack_due = -1; blocked = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_cfg_ack", 64'(cfg_ack), 64'(0));
            m_ptr = 0; m_qh = QH_INIT; blocked = 0; last_issue = -100;
            for (int i = 0; i < NREQ; i++) gnt_cyc[i] = -10;
         end else begin
            exp_rdy = '0;
            g = -1;
            if (!blocked) begin
               for (int k = 0; k < NREQ; k++) begin
                  if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
               end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("cfg_ready", 64'(cfg_ready), 64'(!blocked));
            chk("cfg_ack", 64'(cfg_ack), 64'(blocked && cyc == ack_due));
            chk("qh_cur", 64'(qh_cur), 64'(m_qh));
            if (g >= 0) begin
               a = req_a[g*LOGQ +: LOGQ];
               b = req_b[g*LOGQ +: LOGQ];
               q = qof(m_qh);
               s = {1'b0, a} + {1'b0, b};
               sb.push_back('{id: g, data: LOGQ'(s % {1'b0, q}), due: cyc + LAT});
               m_ptr = (g + 1) % NREQ;
               last_issue = cyc;
               gnt_cyc[g] = cyc;
               glog.push_back(g);
            end
            if (!blocked && cfg_we) begin
               blocked = 1;
               pend = cfg_qh;
               ack_due = ((cyc + 1 > last_issue + LAT + 1) ? cyc + 1 : last_issue + LAT + 1) + 1;
            end else if (blocked && cyc == ack_due) begin
               blocked = 0;
               m_qh = pend;
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      bit   prev_rst;
      prev_rst = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            sb.delete();
            prev_rst = 1;
         end else begin
            if (prev_rst) chk("rst_out_id", 64'(out_id), 64'(0));
            prev_rst = 0;
            while (sb.size() > 0 && sb[0].due < cyc) begin
               fail_msg("missing_result", $sformatf("no out_valid for id %0d due at cycle %0d", sb[0].id, sb[0].due));
               void'(sb.pop_front());
            end
            if (out_valid) begin
               if (sb.size() == 0) begin
                  fail_msg("unexpected_result", $sformatf("out_valid with id %0d data %0h, nothing expected", out_id, out_data));
               end else begin
                  e = sb.pop_front();
                  chk("out_cycle", 64'(cyc), 64'(e.due));
                  chk("out_id", 64'(out_id), 64'(e.id));
                  chk("out_data", out_data, e.data);
               end
            end
         end
      end
   end

   function automatic bit accepted(input int i);
      return gnt_cyc[i] == cyc - 1;
   endfunction

   function automatic logic [LOGQ-1:0] rnd_op(input logic [LOGQ-1:0] q);
      logic [LOGQ-1:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0:       return q - 64'd1;
         1:       return '0;
         default: return r % q;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
      req_a[i*LOGQ +: LOGQ] = a;
      req_b[i*LOGQ +: LOGQ] = b;
   endtask

   task automatic rnd_ops(input int i);
      set_ops(i, rnd_op(qof(m_qh)), rnd_op(qof(m_qh)));
   endtask

   task automatic issue(input int i, input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
      int t;
      set_ops(i, a, b);
      req_valid[i] = 1'b1;
      t = 0;
      do begin
         step();
         t++;
      end while (!accepted(i) && t < 50);
      if (!accepted(i)) fail_msg("issue_timeout", $sformatf("requester %0d never granted", i));
      req_valid[i] = 1'b0;
   endtask

   task automatic cfg_load(input logic [LOGQH-1:0] qh);
      cfg_qh = qh;
      cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
      repeat (4) step();
   endtask

   task automatic wait_grants(input int n);
      int t;
      t = 0;
      while (glog.size() < n && t < 30) begin
         step();
         t++;
         for (int i = 0; i < NREQ; i++) if (accepted(i)) req_valid[i] = 1'b0;
      end
      req_valid = '0;
   endtask

   task automatic chk_log(input string nm, input int ex[$]);
      for (int k = 0; k < ex.size(); k++) begin
         if (k < glog.size()) chk(nm, 64'(glog[k]), 64'(ex[k]));
         else fail_msg(nm, $sformatf("grant %0d missing, expected requester %0d", k, ex[k]));
      end
   endtask

   initial begin : stim
      int               ex[$];
      int               t;
      logic [LOGQH-1:0] drv_qh;
      logic [LOGQH:0]   nq;

      repeat (3) step();
      rst = 1'b0;
      step();

      // single op and wrap cases under q = 131073
      cfg_load(47'd1);
      chk("qh_after_load", 64'(qh_cur), 64'd1);
      issue(0, 64'd5, 64'd7);
      repeat (5) step();
      issue(2, 64'd131072, 64'd2);
      issue(2, 64'd131072, 64'd1);
      issue(1, 64'd0, 64'd0);
      repeat (5) step();

      // saturation straight out of reset (qH back to 0, so operands are 0)
      rst = 1'b1;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      step();
      step();
      glog.delete();
      rst = 1'b0;
      repeat (6) step();
      req_valid = '0;
      ex = '{0, 1, 2, 3, 0, 1};
      chk_log("sat_order", ex);
      repeat (5) step();

      // fairness: ptr is now 2
      cfg_load(47'd1);
      glog.delete();
      rnd_ops(1);
      rnd_ops(3);
      req_valid[1] = 1'b1;
      req_valid[3] = 1'b1;
      t = 0;
      while (glog.size() < 3 && t < 20) begin
         step();
         t++;
         if (accepted(1)) rnd_ops(1);
         if (accepted(3)) rnd_ops(3);
      end
      req_valid = '0;
      rnd_ops(1);
      rnd_ops(2);
      rnd_ops(3);
      req_valid[3:1] = 3'b111;
      wait_grants(6);
      ex = '{3, 1, 3, 1, 2, 3};
      chk_log("fair_order", ex);
      repeat (5) step();

      // reconfigure with two ops in flight, plus an ignored cfg_we during DRAIN
      set_ops(0, 64'd131072, 64'd131072);
      rnd_ops(1);
      req_valid[1:0] = 2'b11;
      step();
      req_valid[0] = 1'b0;
      cfg_qh = 47'd2;
      cfg_we = 1'b1;
      step();
      req_valid[1] = 1'b0;
      cfg_we = 1'b0;
      set_ops(2, 64'd100, 64'd200);
      req_valid[2] = 1'b1;
      step();
      cfg_qh = 47'd7;
      cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
      t = 0;
      while (!accepted(2) && t < 20) begin
         step();
         t++;
      end
      if (!accepted(2)) fail_msg("post_load_grant", "requester 2 not granted after LOAD");
      req_valid[2] = 1'b0;
      repeat (5) step();
      chk("qh_after_reconfig", 64'(qh_cur), 64'd2);
      issue(3, 64'd262144, 64'd1);
      repeat (5) step();

      // reset with three ops in flight and DRAIN pending
      rnd_ops(0);
      rnd_ops(1);
      rnd_ops(2);
      req_valid[2:0] = 3'b111;
      step();
      req_valid[0] = 1'b0;
      step();
      req_valid[1] = 1'b0;
      cfg_qh = 47'd5;
      cfg_we = 1'b1;
      step();
      req_valid[2] = 1'b0;
      cfg_we = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      glog.delete();
      req_a = '0;
      req_b = '0;
      req_valid = '1;
      wait_grants(4);
      ex = '{0, 1, 2, 3};
      chk_log("post_reset_order", ex);
      chk("qh_after_reset", 64'(qh_cur), 64'(QH_INIT));
      repeat (6) step();

      // randomized traffic with monotonically growing qH near the top of the range
      drv_qh = 47'h7FFF_0000_0000 | 47'($urandom);
      for (int c = 0; c < 3000; c++) begin
         cfg_we = 1'b0;
         if (c == 0) begin
            cfg_we = 1'b1;
            cfg_qh = drv_qh;
         end else if ($urandom_range(0, 59) == 0) begin
            nq = {1'b0, drv_qh} + 48'($urandom_range(0, 5000));
            if (nq > {1'b0, {LOGQH{1'b1}}}) nq = {1'b0, {LOGQH{1'b1}}};
            drv_qh = nq[LOGQH-1:0];
            cfg_we = 1'b1;
            cfg_qh = drv_qh;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && accepted(i)) begin
               req_valid[i] = ($urandom_range(0, 9) < 7);
               rnd_ops(i);
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  rnd_ops(i);
                  req_valid[i] = 1'b1;
               end
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         step();
      end
      req_valid = '0;
      cfg_we = 1'b0;
      repeat (10) step();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
